// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer
//   Iterative RISC-V M-extension unit for the EX stage. It computes multiplies
//   (shift-add) and divides (restoring) at one bit per cycle. Divide-by-zero
//   and signed overflow finish through a fast path that skips COMPUTE.
//   The unit handles RV32M, and RV64M (including the W forms) when XLEN=64.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin an operation (sampled in IDLE or DONE)
//   mul_div_op[3:0]       {1'b0, funct3}: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   is_word_op            W-suffix operation (only meaningful when XLEN=64)
//   operand_a, operand_b  rs1 / rs2 (dividend / divisor)
//   flush                 abandon whatever is in flight; wins over start
//   busy                  high while iterating (COMPUTE)
//   done                  one-cycle pulse, result valid
//   result                last completed result, held until the next done

module mul_div_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [3:0]      mul_div_op,
   input  logic            is_word_op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;

   // Sign-extend the low word to XLEN. The s input selects sign or zero fill.
   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
      logic [XLEN-1:0] r;
      r       = {XLEN{s & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;      // {is_div, funct3[1:0]}
   logic              word_q, word_d;
   logic              neg_q, neg_d;    // sign to apply to product / quotient / remainder
   logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
   logic [XLEN-1:0]   acc_q, acc_d;    // product high half / partial remainder
   logic [XLEN-1:0]   lo_q, lo_d;      // product low half (multiplier) / quotient
   logic [XLEN-1:0]   result_q, result_d;

   logic unused_op_msb;
   assign unused_op_msb = mul_div_op[3];

   // ---------------- operand decode for a new request ----------------
   logic            in_word, in_div, a_signed, b_signed, a_neg, b_neg;
   logic [1:0]      in_sel;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_ext, fast_raw, fast_res;
   logic            b_zero, ovf, fast, launch;

   assign in_word  = (XLEN == 64) && is_word_op;
   assign in_div   = mul_div_op[2];
   assign in_sel   = mul_div_op[1:0];
   assign a_signed = in_div ? ~in_sel[0] : (in_sel != 2'd3);
   assign b_signed = in_div ? ~in_sel[0] : ~in_sel[1];
   assign a_ext    = in_word ? ext32(operand_a[31:0], a_signed) : operand_a;
   assign b_ext    = in_word ? ext32(operand_b[31:0], b_signed) : operand_b;
   assign a_neg    = a_signed & a_ext[XLEN-1];
   assign b_neg    = b_signed & b_ext[XLEN-1];
   assign a_mag    = a_neg ? -a_ext : a_ext;
   assign b_mag    = b_neg ? -b_ext : b_ext;

   // Most-negative N-bit value, already extended to XLEN like a_ext.
   assign min_ext  = in_word ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
   assign b_zero   = (b_ext == '0);
   assign ovf      = ~in_sel[0] && (a_ext == min_ext) && (b_ext == '1);
   assign fast     = in_div && (b_zero || ovf);
   // sel[1] distinguishes REM/REMU from DIV/DIVU.
   assign fast_raw = b_zero ? (in_sel[1] ? a_ext : '1)
                            : (in_sel[1] ? '0    : a_ext);
   assign fast_res = in_word ? ext32(fast_raw[31:0], 1'b1) : fast_raw;

   assign launch   = start && !flush && (state_q != S_COMPUTE);

   // ---------------- one iteration of the active algorithm ----------------
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic            div_ok;
   logic [XLEN-1:0] iter_acc, iter_lo;

   assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {acc_q, lo_q[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_ok    = ~div_diff[XLEN];   // no borrow: divisor fits
   assign iter_acc  = op_q[2] ? (div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0])
                              : mul_sum[XLEN:1];
   assign iter_lo   = op_q[2] ? {lo_q[XLEN-2:0], div_ok}
                              : {mul_sum[0], lo_q[XLEN-1:1]};

   // ---------------- sign fix-up of the final iteration ----------------
   // A word multiply runs 32 steps, which leaves the product 32 bits above
   // its natural position; the shift below realigns it.
   logic [2*XLEN-1:0] prod, prod_n, prod_s;
   logic [XLEN-1:0]   mul_raw, div_raw, fin_raw, fin_res;

   assign prod    = {iter_acc, iter_lo};
   assign prod_n  = word_q ? (prod >> (XLEN - 32)) : prod;
   assign prod_s  = neg_q ? -prod_n : prod_n;
   assign mul_raw = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0]
                  : (word_q ? XLEN'(prod_s[63:32]) : prod_s[2*XLEN-1:XLEN]);
   assign div_raw = op_q[1] ? (neg_q ? -iter_acc : iter_acc)
                            : (neg_q ? -iter_lo  : iter_lo);
   assign fin_raw = op_q[2] ? div_raw : mul_raw;
   assign fin_res = word_q ? ext32(fin_raw[31:0], 1'b1) : fin_raw;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (launch) state_d = fast ? S_DONE : S_COMPUTE;
               else        state_d = S_IDLE;
            end
            S_COMPUTE: if (cnt_q == CW'(1)) state_d = S_DONE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy   = (state_q == S_COMPUTE);
      done   = (state_q == S_DONE);
      result = result_q;
   end

   // ---------------- datapath next state ----------------
   // NOTE: every variable gets a hold default first so no path infers a latch.
   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      word_d   = word_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      result_d = result_q;
      if (launch) begin
         op_d   = {in_div, in_sel};
         word_d = in_word;
         neg_d  = (in_div && in_sel[1]) ? a_neg : (a_neg ^ b_neg);
         opnd_d = in_div ? b_mag : a_mag;
         acc_d  = '0;
         lo_d   = in_div ? (in_word ? (a_mag << (XLEN - 32)) : a_mag) : b_mag;
         if (fast) result_d = fast_res;
         else      cnt_d    = in_word ? CW'(32) : CW'(XLEN);
      end else if (state_q == S_COMPUTE && !flush) begin
         acc_d = iter_acc;
         lo_d  = iter_lo;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) result_d = fin_res;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer
//   Two instances (XLEN=32 and XLEN=64) share one clock and reset. Directed
//   vectors push their hand-computed result, completion cycle and busy length
//   into a per-instance queue. A monitor per instance pops on every done.
//   Flush and reset cases push nothing, so any done they produce is reported.

module tb_mul_div_sequencer;

   typedef struct {
      logic [63:0] res;
      int          cyc;
      int          busy;
      string       name;
   } exp_t;

   logic        clk, reset_n;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic        start32, word32, flush32, busy32, done32;
   logic [3:0]  op32;
   logic [31:0] a32, b32, res32;
   logic        start64, word64, flush64, busy64, done64;
   logic [3:0]  op64;
   logic [63:0] a64, b64, res64;

   exp_t q32[$];
   exp_t q64[$];
   int   busy_run32 = 0;
   int   busy_run64 = 0;

   mul_div_sequencer #(.XLEN(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .start(start32), .mul_div_op(op32),
      .is_word_op(word32), .operand_a(a32), .operand_b(b32), .flush(flush32),
      .busy(busy32), .done(done32), .result(res32)
   );

   mul_div_sequencer #(.XLEN(64)) dut64 (
      .clk(clk), .reset_n(reset_n), .start(start64), .mul_div_op(op64),
      .is_word_op(word64), .operand_a(a64), .operand_b(b64), .flush(flush64),
      .busy(busy64), .done(done64), .result(res64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      exp_t e;
      if (done32) begin
         if (q32.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done32: got done=1, expected no done");
         end else begin
            e = q32.pop_front();
            check(e.name, {32'b0, res32}, e.res);
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            check({e.name, "_busy"}, 64'(busy_run32), 64'(e.busy));
         end
         busy_run32 = 0;
      end else if (busy32) busy_run32++;
      else busy_run32 = 0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (done64) begin
         if (q64.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done64: got done=1, expected no done");
         end else begin
            e = q64.pop_front();
            check(e.name, res64, e.res);
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            check({e.name, "_busy"}, 64'(busy_run64), 64'(e.busy));
         end
         busy_run64 = 0;
      end else if (busy64) busy_run64++;
      else busy_run64 = 0;
   end

   // ---------------- stimulus helpers ----------------
   // Called just after a rising edge; start is sampled on the next edge (E0).
   task automatic issue(input bit w64, input logic [3:0] op, input bit word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat,
                        input bit expect_done, input bit hold, input string name);
      exp_t e;
      if (w64) begin
         op64 = op; word64 = word; a64 = a; b64 = b; start64 = 1'b1;
      end else begin
         op32 = op; word32 = word; a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1;
      end
      if (expect_done) begin
         e.res = exp; e.cyc = cyc + 1 + lat; e.busy = lat; e.name = name;
         if (w64) q64.push_back(e);
         else     q32.push_back(e);
      end
      @(posedge clk); #1;
      if (!hold) begin
         start32 = 1'b0;
         start64 = 1'b0;
      end
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((q32.size() != 0 || q64.size() != 0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (q32.size() != 0 || q64.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d/%0d pending, expected 0/0", q32.size(), q64.size());
         q32.delete();
         q64.delete();
      end
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      exp_t e;
      reset_n = 1'b0;
      start32 = 1'b0; word32 = 1'b0; flush32 = 1'b0; op32 = 4'd0; a32 = '0; b32 = '0;
      start64 = 1'b0; word64 = 1'b0; flush64 = 1'b0; op64 = 4'd0; a64 = '0; b64 = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset_busy32",   {63'b0, busy32}, 64'd0);
      check("reset_done32",   {63'b0, done32}, 64'd0);
      check("reset_result32", {32'b0, res32},  64'd0);
      check("reset_busy64",   {63'b0, busy64}, 64'd0);
      check("reset_done64",   {63'b0, done64}, 64'd0);
      check("reset_result64", res64,           64'd0);

      // XLEN=32 multiply, full 32-step latency
      issue(0, 4'd0, 0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 32, 1, 0, "mul_7_m3");
      wait_drain(100);

      // signed-overflow and divide-by-zero fast paths
      issue(0, 4'd4, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0, 1, 0, "div_ovf");
      wait_drain(20);
      issue(0, 4'd6, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000, 0, 1, 0, "rem_ovf");
      wait_drain(20);
      issue(0, 4'd5, 0, 64'd100, 64'd0, 64'hFFFF_FFFF, 0, 1, 0, "divu_by0");
      wait_drain(20);
      issue(0, 4'd7, 0, 64'd100, 64'd0, 64'h0000_0064, 0, 1, 0, "remu_by0");
      wait_drain(20);

      // back-to-back: second op presented with start held through DONE
      issue(0, 4'd3, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 32, 1, 1, "mulhu_b2b");
      op32 = 4'd2; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
      e.res = 64'hFFFF_FFFF; e.cyc = cyc + 65; e.busy = 32; e.name = "mulhsu_b2b";
      q32.push_back(e);
      repeat (33) @(posedge clk);
      #1 start32 = 1'b0;
      wait_drain(100);

      // flush and start together: flush wins, nothing starts
      flush32 = 1'b1;
      issue(0, 4'd0, 0, 64'd3, 64'd5, 64'd0, 0, 0, 0, "flush_start");
      flush32 = 1'b0;
      check("flush_start_busy", {63'b0, busy32}, 64'd0);
      check("flush_start_done", {63'b0, done32}, 64'd0);
      check("flush_start_result", {32'b0, res32}, 64'hFFFF_FFFF);

      // flush during DONE: pulse stands, held start does not relaunch
      issue(0, 4'd7, 0, 64'h55, 64'd0, 64'h55, 0, 1, 1, "remu_flush_done");
      flush32 = 1'b1;
      @(posedge clk); #1;
      check("flush_done_next_done", {63'b0, done32}, 64'd0);
      check("flush_done_next_busy", {63'b0, busy32}, 64'd0);
      flush32 = 1'b0;
      start32 = 1'b0;
      wait_drain(20);

      // flush in COMPUTE cycle 10, then restart the same REM
      issue(0, 4'd6, 0, 64'hFFFF_FFF9, 64'd2, 64'd0, 0, 0, 0, "rem_flushed");
      repeat (9) @(posedge clk);
      #1 flush32 = 1'b1;
      @(posedge clk); #1;
      flush32 = 1'b0;
      check("flush_compute_busy", {63'b0, busy32}, 64'd0);
      check("flush_compute_done", {63'b0, done32}, 64'd0);
      repeat (40) @(posedge clk);
      #1 check("flush_compute_result", {32'b0, res32}, 64'h55);
      issue(0, 4'd6, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 32, 1, 0, "rem_m7_2");
      wait_drain(100);

      // reset pulse mid-COMPUTE: outputs clear at once, no done
      issue(0, 4'd6, 0, 64'hFFFF_FFF9, 64'd2, 64'd0, 0, 0, 0, "rem_reset");
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_busy",   {63'b0, busy32}, 64'd0);
      check("midreset_done",   {63'b0, done32}, 64'd0);
      check("midreset_result", {32'b0, res32},  64'd0);
      @(negedge clk) reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #1 check("after_reset_result", {32'b0, res32}, 64'd0);

      // XLEN=64: word and full-width forms
      issue(1, 4'd4, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1, 0, "divw");
      wait_drain(100);
      issue(1, 4'd4, 0, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 64, 1, 0, "div64");
      wait_drain(150);
      issue(1, 4'd7, 1, 64'h1234_5678_8765_4321, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8765_4321, 0, 1, 0, "remuw_by0");
      wait_drain(20);
      issue(1, 4'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64, 1, 0, "mulhu64");
      wait_drain(150);
      issue(1, 4'd0, 1, 64'h0000_0001_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 32, 1, 0, "mulw_wrap");
      wait_drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
